// File: rtl/stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stall_pkg
// Shared constants and helpers for the pipeline stall controller.
//   MULT_LAT / DIV_LAT : default MDU busy cycles following a mult / div start
//   T_W, tcyc_t        : width and type of the Tuse / Tnew cycle counts
//   TUSE_NONE          : Tuse value meaning "this source operand is not read"
//   MD_CNT_W           : width of the MDU countdown register
//   src_hazard()       : one source-vs-one-producer hazard term
// -----------------------------------------------------------------------------
package stall_pkg;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int MD_CNT_W = 4;

  localparam int T_W = 2;
  typedef logic [T_W-1:0] tcyc_t;

  localparam tcyc_t TUSE_NONE = 2'd3;

  // A source needs to wait when a younger-stage producer writes that register
  // and its value will not be forwardable before the consumer needs it.
  // $0 is hard-wired zero and never creates a dependency. A TUSE_NONE source
  // can never be smaller than a 2-bit Tnew, so the explicit test only makes
  // the intent visible.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input tcyc_t      tuse,
    input logic       regwrite,
    input logic [4:0] a3,
    input tcyc_t      tnew
  );
    return (src != 5'd0) && (tuse != TUSE_NONE) && regwrite &&
           (a3 == src) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// stall_ctrl_if
// Bundle of the hazard inputs and pipeline-control outputs of stall_ctrl.
//   master : pipeline side (drives ID/EX/MA status, reads enables/clears)
//   slave  : stall controller side
// -----------------------------------------------------------------------------
interface stall_ctrl_if;
  import stall_pkg::*;

  // ID stage sources
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  tcyc_t      id_tuse_rs;
  tcyc_t      id_tuse_rt;
  logic       id_md;

  // EX / MA producers
  logic [4:0] ex_a3;
  logic [4:0] ma_a3;
  logic       ex_regwrite;
  logic       ma_regwrite;
  tcyc_t      ex_tnew;
  tcyc_t      ma_tnew;

  // MDU start
  logic       ex_md_start;
  logic       ex_md_div;

  // Global freeze
  logic       halt;

  // Pipeline control
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_ma_en;
  logic       id_ex_clr;
  logic       ex_ma_clr;
  logic       md_busy;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md,
           ex_a3, ma_a3, ex_regwrite, ma_regwrite, ex_tnew, ma_tnew,
           ex_md_start, ex_md_div, halt,
    input  pc_en, if_id_en, id_ex_en, ex_ma_en, id_ex_clr, ex_ma_clr,
           md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md,
           ex_a3, ma_a3, ex_regwrite, ma_regwrite, ex_tnew, ma_tnew,
           ex_md_start, ex_md_div, halt,
    output pc_en, if_id_en, id_ex_en, ex_ma_en, id_ex_clr, ex_ma_clr,
           md_busy, stall_cnt
  );

endinterface

// File: rtl/stall_ctrl_md_busy_timer.sv
// -----------------------------------------------------------------------------
// md_busy_timer
// Tracks how long the multiply/divide unit stays occupied after a start.
//   clk, reset      : clock, asynchronous active-high reset
//   halt_i          : pipeline frozen; countdown holds, starts are ignored
//   ex_md_start_i   : EX instruction starts the MDU this cycle
//   ex_md_div_i     : start is a divide (1) or a multiply (0)
//   md_busy_o       : MDU occupied (combinational, includes the start cycle)
// -----------------------------------------------------------------------------
module md_busy_timer
  import stall_pkg::*;
#(
  parameter int MULT_LAT = stall_pkg::MULT_LAT,
  parameter int DIV_LAT  = stall_pkg::DIV_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic halt_i,
  input  logic ex_md_start_i,
  input  logic ex_md_div_i,
  output logic md_busy_o
);

  logic [MD_CNT_W-1:0] md_cnt_q;
  logic [MD_CNT_W-1:0] md_cnt_d;

  // A start only loads an idle counter; a start arriving mid-operation is
  // dropped and the running countdown carries on.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (!halt_i) begin
      if (ex_md_start_i && (md_cnt_q == '0)) begin
        md_cnt_d = ex_md_div_i ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MULT_LAT);
      end else if (md_cnt_q != '0) begin
        md_cnt_d = md_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  // The start cycle itself already counts as busy.
  assign md_busy_o = ex_md_start_i | (md_cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
// Pipeline hazard detection and pipeline-register control.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : stall_ctrl_if.slave
//                in : ID sources/Tuse, EX/MA dest/regwrite/Tnew, MDU start,
//                     halt
//                out: pc_en, if_id_en, id_ex_en, ex_ma_en, id_ex_clr,
//                     ex_ma_clr, md_busy, stall_cnt (saturating stall count)
// -----------------------------------------------------------------------------
module stall_ctrl
  import stall_pkg::*;
#(
  parameter int MULT_LAT = stall_pkg::MULT_LAT,
  parameter int DIV_LAT  = stall_pkg::DIV_LAT
) (
  input  logic         clk,
  input  logic         reset,
  stall_ctrl_if.slave  bus
);

  logic [4:0] src    [2];
  tcyc_t      tuse   [2];
  logic [1:0] src_hz;
  logic       data_stall;
  logic       md_stall;
  logic       md_busy;
  logic       stall;

  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  assign src[0]  = bus.id_rs;
  assign src[1]  = bus.id_rt;
  assign tuse[0] = bus.id_tuse_rs;
  assign tuse[1] = bus.id_tuse_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hz[gi] =
        src_hazard(src[gi], tuse[gi], bus.ex_regwrite, bus.ex_a3, bus.ex_tnew) |
        src_hazard(src[gi], tuse[gi], bus.ma_regwrite, bus.ma_a3, bus.ma_tnew);
    end
  endgenerate

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_timer (
    .clk           (clk),
    .reset         (reset),
    .halt_i        (bus.halt),
    .ex_md_start_i (bus.ex_md_start),
    .ex_md_div_i   (bus.ex_md_div),
    .md_busy_o     (md_busy)
  );

  assign data_stall = |src_hz;
  assign md_stall   = bus.id_md & md_busy;
  // Halt overrides everything, so a halted cycle is never a stall cycle.
  assign stall      = (data_stall | md_stall) & ~bus.halt;

  // A stall freezes PC and IF/ID and injects a bubble into ID/EX; the back
  // end keeps draining. Halt freezes every stage and suppresses clears.
  always_comb begin
    bus.pc_en     = 1'b1;
    bus.if_id_en  = 1'b1;
    bus.id_ex_en  = 1'b1;
    bus.ex_ma_en  = 1'b1;
    bus.id_ex_clr = 1'b0;
    bus.ex_ma_clr = 1'b0;
    if (bus.halt) begin
      bus.pc_en    = 1'b0;
      bus.if_id_en = 1'b0;
      bus.id_ex_en = 1'b0;
      bus.ex_ma_en = 1'b0;
    end else if (stall) begin
      bus.pc_en     = 1'b0;
      bus.if_id_en  = 1'b0;
      bus.id_ex_clr = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.md_busy   = md_busy;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;
  import stall_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stall_ctrl_if bus ();

  stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  en;    // {pc_en, if_id_en, id_ex_en, ex_ma_en}
    logic [1:0]  clr;   // {id_ex_clr, ex_ma_clr}
    logic        busy;
    logic [15:0] scnt;
  } exp_t;

  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  bit verbose = 1'b1;

  // Reference state: remaining MDU busy cycles after the start cycle, and
  // the expected stall counter value.
  int          m_rem  = 0;
  logic [15:0] m_scnt = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic dep(input logic [4:0] src, input logic [1:0] tuse);
    logic d;
    d = 1'b0;
    if (src != 5'd0 && tuse != 2'd3) begin
      if (bus.ex_regwrite && bus.ex_a3 == src && tuse < bus.ex_tnew) d = 1'b1;
      if (bus.ma_regwrite && bus.ma_a3 == src && tuse < bus.ma_tnew) d = 1'b1;
    end
    return d;
  endfunction

  task automatic clear_inputs();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_tuse_rs = 0; bus.id_tuse_rt = 0;
    bus.id_md = 0; bus.ex_a3 = 0; bus.ma_a3 = 0; bus.ex_regwrite = 0;
    bus.ma_regwrite = 0; bus.ex_tnew = 0; bus.ma_tnew = 0;
    bus.ex_md_start = 0; bus.ex_md_div = 0; bus.halt = 0;
  endtask

  // One clock cycle: predict outputs for the inputs already driven, push the
  // prediction, compare at the falling edge, then advance the reference at
  // the rising edge. Returns 1 time unit after that rising edge.
  task automatic cycle();
    exp_t e;
    exp_t o;
    logic ds, busy, st;
    ds   = dep(bus.id_rs, bus.id_tuse_rs) | dep(bus.id_rt, bus.id_tuse_rt);
    busy = bus.ex_md_start || (m_rem > 0);
    st   = (ds || (bus.id_md && busy)) && !bus.halt;
    e.en   = bus.halt ? 4'b0000 : {~st, ~st, 2'b11};
    e.clr  = bus.halt ? 2'b00 : {st, 1'b0};
    e.busy = busy;
    e.scnt = m_scnt;
    sb_q.push_back(e);

    @(negedge clk);
    o = sb_q.pop_front();
    check("en",   {28'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_ma_en}, {28'd0, o.en});
    check("clr",  {30'd0, bus.id_ex_clr, bus.ex_ma_clr}, {30'd0, o.clr});
    check("busy", {31'd0, bus.md_busy}, {31'd0, o.busy});
    check("scnt", {16'd0, bus.stall_cnt}, {16'd0, o.scnt});
    txn++;
    if (verbose)
      $display("txn %0d: en=%b clr=%b busy=%b scnt=%0d (exp en=%b clr=%b busy=%b scnt=%0d)",
               txn, {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_ma_en},
               {bus.id_ex_clr, bus.ex_ma_clr}, bus.md_busy, bus.stall_cnt,
               o.en, o.clr, o.busy, o.scnt);

    @(posedge clk);
    if (reset) begin
      m_rem  = 0;
      m_scnt = 16'd0;
    end else begin
      if (!bus.halt) begin
        if (m_rem == 0 && bus.ex_md_start) m_rem = bus.ex_md_div ? 10 : 5;
        else if (m_rem > 0)                m_rem = m_rem - 1;
      end
      if (st && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
    end
    #1;
  endtask

  initial begin
    int busy_seen;
    clear_inputs();

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.md_busy}, 32'd0);
    check("rst_scnt", {16'd0, bus.stall_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle after reset: everything enabled.
    cycle();
    cycle();

    // Load-use hazard on rs via EX.
    bus.id_rs = 5; bus.id_tuse_rs = 1; bus.ex_a3 = 5; bus.ex_regwrite = 1; bus.ex_tnew = 2;
    cycle();
    check("lu_scnt", {16'd0, bus.stall_cnt}, 32'd1);
    // $0 never stalls.
    bus.id_rs = 0; bus.ex_a3 = 0;
    cycle();
    // Result already forwardable.
    bus.id_rs = 5; bus.ex_a3 = 5; bus.ex_tnew = 1;
    cycle();
    // rt against MA producer; unused rs (Tuse=3) against a late EX result.
    clear_inputs();
    bus.id_rt = 7; bus.id_tuse_rt = 0; bus.ma_a3 = 7; bus.ma_regwrite = 1; bus.ma_tnew = 1;
    cycle();
    clear_inputs();
    bus.id_rs = 9; bus.id_tuse_rs = 3; bus.ex_a3 = 9; bus.ex_regwrite = 1; bus.ex_tnew = 3;
    cycle();
    clear_inputs();
    cycle();
    check("pre_div_scnt", {16'd0, bus.stall_cnt}, 32'd2);

    // Divide: 11 busy cycles with id_md held, then release. Data hazard
    // coincides in the start cycle and must count only once.
    bus.id_md = 1; bus.ex_md_start = 1; bus.ex_md_div = 1;
    bus.id_rs = 4; bus.id_tuse_rs = 0; bus.ex_a3 = 4; bus.ex_regwrite = 1; bus.ex_tnew = 1;
    cycle();
    clear_inputs();
    bus.id_md = 1;
    busy_seen = 1;
    repeat (11) begin
      if (bus.md_busy) busy_seen++;
      cycle();
    end
    check("div_busy_len", busy_seen, 11);
    check("div_scnt", {16'd0, bus.stall_cnt}, 32'd13);

    // Multiply, then a second start while md_cnt = 3 is ignored.
    clear_inputs();
    bus.ex_md_start = 1;
    cycle();
    bus.ex_md_start = 0;
    cycle();
    cycle();
    bus.ex_md_start = 1;
    cycle();
    bus.ex_md_start = 0;
    cycle();
    cycle();
    check("ign_busy_end", {31'd0, bus.md_busy}, 32'd0);
    cycle();

    // Halt during divide countdown.
    bus.ex_md_start = 1; bus.ex_md_div = 1;
    cycle();
    bus.ex_md_start = 0;
    cycle();
    bus.halt = 1; bus.id_md = 1;
    bus.id_rs = 4; bus.id_tuse_rs = 0; bus.ex_a3 = 4; bus.ex_regwrite = 1; bus.ex_tnew = 2;
    repeat (3) cycle();
    check("halt_scnt", {16'd0, bus.stall_cnt}, 32'd13);
    clear_inputs();
    bus.id_md = 1;
    repeat (10) cycle();
    check("halt_resume_scnt", {16'd0, bus.stall_cnt}, 32'd22);
    // Start under halt with an idle MDU is ignored.
    clear_inputs();
    bus.halt = 1; bus.ex_md_start = 1; bus.ex_md_div = 1;
    cycle();
    clear_inputs();
    cycle();
    check("halt_start_ign", {31'd0, bus.md_busy}, 32'd0);

    // Saturation: 70000 consecutive stall cycles.
    verbose = 1'b0;
    bus.id_rs = 5; bus.id_tuse_rs = 1; bus.ex_a3 = 5; bus.ex_regwrite = 1; bus.ex_tnew = 2;
    repeat (70000) cycle();
    verbose = 1'b1;
    cycle();
    check("sat_scnt", {16'd0, bus.stall_cnt}, 32'h0000FFFF);

    // Asynchronous reset in the middle of a divide countdown.
    clear_inputs();
    bus.ex_md_start = 1; bus.ex_md_div = 1;
    cycle();
    bus.ex_md_start = 0;
    cycle();
    #1 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.md_busy}, 32'd0);
    check("arst_scnt", {16'd0, bus.stall_cnt}, 32'd0);
    m_rem = 0;
    m_scnt = 16'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle();
    cycle();

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
